// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one memory bus between
// instruction fetch and load/store, with a bus watchdog.
module mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_req,
    input  logic [AW-1:0]   i_if_addr,
    output logic            o_if_ready,
    output logic [DW-1:0]   o_if_data,
    input  logic            i_d_rd_req,
    input  logic            i_d_wr_req,
    input  logic [AW-1:0]   i_d_addr,
    input  logic [DW/8-1:0] i_d_be,
    input  logic [DW-1:0]   i_d_wr_data,
    output logic            o_d_rd_ready,
    output logic            o_d_wr_ready,
    output logic [DW-1:0]   o_d_rd_data,
    output logic            o_m_rd_req,
    output logic            o_m_wr_req,
    output logic [AW-1:0]   o_m_addr,
    output logic [DW/8-1:0] o_m_be,
    output logic [DW-1:0]   o_m_wr_data,
    input  logic            i_m_ack,
    input  logic [DW-1:0]   i_m_rd_data,
    output logic            o_bus_err
);

    localparam int BW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

    state_t          r_state, w_state;
    logic            r_last_d, w_last_d;
    logic            r_wr, w_wr;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [AW-1:0]   r_m_addr, w_m_addr;
    logic [BW-1:0]   r_m_be, w_m_be;
    logic [DW-1:0]   r_m_wdata, w_m_wdata;
    logic            r_m_rd_req, w_m_rd_req;
    logic            r_m_wr_req, w_m_wr_req;
    logic [DW-1:0]   r_if_data, w_if_data;
    logic [DW-1:0]   r_d_rd_data, w_d_rd_data;
    logic            r_if_ready, w_if_ready;
    logic            r_d_rd_ready, w_d_rd_ready;
    logic            r_d_wr_ready, w_d_wr_ready;
    logic            r_bus_err, w_bus_err;
    logic            w_d_req, w_pick_i, w_done, w_tout;
    logic [DW-1:0]   w_rdata;

    // Next-state and next-register values for the arbiter FSM
    always_comb begin
        w_state      = r_state;
        w_last_d     = r_last_d;
        w_wr         = r_wr;
        w_cnt        = r_cnt;
        w_m_addr     = r_m_addr;
        w_m_be       = r_m_be;
        w_m_wdata    = r_m_wdata;
        w_m_rd_req   = r_m_rd_req;
        w_m_wr_req   = r_m_wr_req;
        w_if_data    = r_if_data;
        w_d_rd_data  = r_d_rd_data;
        w_if_ready   = 1'b0;
        w_d_rd_ready = 1'b0;
        w_d_wr_ready = 1'b0;
        w_bus_err    = 1'b0;
        w_done       = 1'b0;
        w_tout       = 1'b0;
        w_rdata      = '0;
        w_d_req      = i_d_rd_req | i_d_wr_req;
        w_pick_i     = i_if_req & (~w_d_req | r_last_d);
        unique case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (w_pick_i) begin
                    w_state    = BUS_I;
                    w_last_d   = 1'b0;
                    w_wr       = 1'b0;
                    w_m_addr   = i_if_addr;
                    w_m_be     = '1;
                    w_m_wdata  = '0;
                    w_m_rd_req = 1'b1;
                end else if (w_d_req) begin
                    w_state    = BUS_D;
                    w_last_d   = 1'b1;
                    w_wr       = i_d_wr_req;
                    w_m_addr   = i_d_addr;
                    w_m_be     = i_d_be;
                    w_m_wdata  = i_d_wr_data;
                    w_m_rd_req = ~i_d_wr_req;
                    w_m_wr_req = i_d_wr_req;
                end
            end
            BUS_I, BUS_D: begin
                if (i_m_ack) begin
                    w_done  = 1'b1;
                    w_rdata = r_wr ? '0 : i_m_rd_data;
                end else if (TIMEOUT != 0 && r_cnt == TMAX) begin
                    w_done = 1'b1;
                    w_tout = 1'b1;
                end else if (r_cnt != '1) begin
                    w_cnt = r_cnt + 1'b1;
                end
                if (w_done) begin
                    w_state    = RESP;
                    w_m_rd_req = 1'b0;
                    w_m_wr_req = 1'b0;
                    w_bus_err  = w_tout;
                    if (r_state == BUS_I) begin
                        w_if_ready = 1'b1;
                        w_if_data  = w_rdata;
                    end else if (r_wr) begin
                        w_d_wr_ready = 1'b1;
                    end else begin
                        w_d_rd_ready = 1'b1;
                        w_d_rd_data  = w_rdata;
                    end
                end
            end
            RESP: w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Latched request fields, watchdog and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_d     <= 1'b0;
            r_wr         <= 1'b0;
            r_cnt        <= '0;
            r_m_addr     <= '0;
            r_m_be       <= '0;
            r_m_wdata    <= '0;
            r_m_rd_req   <= 1'b0;
            r_m_wr_req   <= 1'b0;
            r_if_data    <= '0;
            r_d_rd_data  <= '0;
            r_if_ready   <= 1'b0;
            r_d_rd_ready <= 1'b0;
            r_d_wr_ready <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_last_d     <= w_last_d;
            r_wr         <= w_wr;
            r_cnt        <= w_cnt;
            r_m_addr     <= w_m_addr;
            r_m_be       <= w_m_be;
            r_m_wdata    <= w_m_wdata;
            r_m_rd_req   <= w_m_rd_req;
            r_m_wr_req   <= w_m_wr_req;
            r_if_data    <= w_if_data;
            r_d_rd_data  <= w_d_rd_data;
            r_if_ready   <= w_if_ready;
            r_d_rd_ready <= w_d_rd_ready;
            r_d_wr_ready <= w_d_wr_ready;
            r_bus_err    <= w_bus_err;
        end
    end

    assign o_if_ready   = r_if_ready;
    assign o_if_data    = r_if_data;
    assign o_d_rd_ready = r_d_rd_ready;
    assign o_d_wr_ready = r_d_wr_ready;
    assign o_d_rd_data  = r_d_rd_data;
    assign o_m_rd_req   = r_m_rd_req;
    assign o_m_wr_req   = r_m_wr_req;
    assign o_m_addr     = r_m_addr;
    assign o_m_be       = r_m_be;
    assign o_m_wr_data  = r_m_wdata;
    assign o_bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scoreboard bench for mem_arb
// (fetch, write, timeout, busy-change, round-robin, reset abort).
module tb_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_ready;
    logic [31:0]   if_data;
    logic          d_rd_req = 1'b0;
    logic          d_wr_req = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [3:0]    d_be = '0;
    logic [31:0]   d_wr_data = '0;
    logic          d_rd_ready;
    logic          d_wr_ready;
    logic [31:0]   d_rd_data;
    logic          m_rd_req;
    logic          m_wr_req;
    logic [31:0]   m_addr;
    logic [3:0]    m_be;
    logic [31:0]   m_wr_data;
    logic          m_ack = 1'b0;
    logic [31:0]   m_rd_data = '0;
    logic          bus_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0]  rdy;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t exp_q[$];

    mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_ready(if_ready), .o_if_data(if_data),
        .i_d_rd_req(d_rd_req), .i_d_wr_req(d_wr_req),
        .i_d_addr(d_addr), .i_d_be(d_be), .i_d_wr_data(d_wr_data),
        .o_d_rd_ready(d_rd_ready), .o_d_wr_ready(d_wr_ready),
        .o_d_rd_data(d_rd_data),
        .o_m_rd_req(m_rd_req), .o_m_wr_req(m_wr_req),
        .o_m_addr(m_addr), .o_m_be(m_be), .o_m_wr_data(m_wr_data),
        .i_m_ack(m_ack), .i_m_rd_data(m_rd_data),
        .o_bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] r, input logic [31:0] d,
                        input logic err);
        resp_t e;
        e.rdy  = r;
        e.data = d;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // Bus phase: acts as memory, acks on bus cycle 'delay' (-1 = never)
    task automatic bus_phase(input int delay, input logic [31:0] rd,
                             input logic [31:0] addr, input logic [3:0] be,
                             input logic wr, input logic [31:0] wdata,
                             input logic scramble, output int n);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (!(m_rd_req || m_wr_req)) break;
            n++;
            chk("bus_addr", m_addr, addr);
            chk("bus_be", 32'(m_be), 32'(be));
            chk("bus_kind", {30'b0, m_rd_req, m_wr_req}, {30'b0, ~wr, wr});
            if (wr) chk("bus_wdata", m_wr_data, wdata);
            chk("bus_quiet",
                32'({if_ready, d_rd_ready, d_wr_ready, bus_err}), 32'(0));
            m_ack     = (i == delay);
            m_rd_data = (i == delay) ? rd : 32'hBADBAD00;
            if (scramble) begin
                d_addr    = 32'hFFFF0000 ^ 32'(i);
                d_be      = 4'h0;
                d_wr_data = ~d_wr_data;
            end
            step();
        end
        m_ack     = 1'b0;
        m_rd_data = '0;
    endtask

    task automatic resp_phase();
        resp_t e;
        chk("sb_depth", 32'(exp_q.size()), 32'(1));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("ready", 32'({if_ready, d_rd_ready, d_wr_ready}), 32'(e.rdy));
        chk("bus_err", 32'(bus_err), 32'(e.err));
        if (e.rdy == 3'b100) chk("if_data", if_data, e.data);
        if (e.rdy == 3'b010) chk("d_rd_data", d_rd_data, e.data);
    endtask

    task automatic idle_check(input string tag);
        chk(tag, 32'({if_ready, d_rd_ready, d_wr_ready, bus_err,
                      m_rd_req, m_wr_req}), 32'(0));
    endtask

    initial begin
        int n;
        int t_ready[4];

        step();
        step();
        idle_check("rst_ctrl");
        chk("rst_addr", m_addr, 32'h0);
        chk("rst_wdata", m_wr_data, 32'h0);
        chk("rst_be", 32'(m_be), 32'h0);
        chk("rst_data", if_data | d_rd_data, 32'h0);
        rst = 1'b0;

        // single fetch, immediate ack
        if_req  = 1'b1;
        if_addr = 32'h100;
        push(3'b100, 32'hDEADBEEF, 1'b0);
        step();
        bus_phase(0, 32'hDEADBEEF, 32'h100, 4'hF, 1'b0, 32'h0, 1'b0, n);
        chk("fetch_len", 32'(n), 32'(1));
        resp_phase();
        step();
        if_req = 1'b0;
        idle_check("fetch_after");

        // single write, ack after 4 wait cycles
        d_wr_req  = 1'b1;
        d_addr    = 32'h2000;
        d_be      = 4'h3;
        d_wr_data = 32'h1234;
        push(3'b001, 32'h0, 1'b0);
        step();
        bus_phase(4, 32'h0, 32'h2000, 4'h3, 1'b1, 32'h1234, 1'b0, n);
        chk("write_len", 32'(n), 32'(5));
        resp_phase();
        step();
        d_wr_req = 1'b0;
        idle_check("write_after");

        // watchdog timeout on a data read
        d_rd_req = 1'b1;
        d_addr   = 32'h4000;
        d_be     = 4'hF;
        push(3'b010, 32'h0, 1'b1);
        step();
        bus_phase(-1, 32'h0, 32'h4000, 4'hF, 1'b0, 32'h0, 1'b0, n);
        chk("tout_len", 32'(n), 32'(TO + 1));
        resp_phase();
        step();
        d_rd_req = 1'b0;
        idle_check("tout_after");

        // request fields change while the bus is busy
        d_rd_req = 1'b1;
        d_addr   = 32'h3000;
        d_be     = 4'hC;
        push(3'b010, 32'hCAFEF00D, 1'b0);
        step();
        bus_phase(3, 32'hCAFEF00D, 32'h3000, 4'hC, 1'b0, 32'h0, 1'b1, n);
        chk("busy_len", 32'(n), 32'(4));
        resp_phase();
        step();
        d_rd_req = 1'b0;
        idle_check("busy_after");

        // continuous conflict from reset: D, I, D, I
        rst      = 1'b1;
        if_req   = 1'b1;
        d_rd_req = 1'b1;
        if_addr  = 32'h300;
        d_addr   = 32'h400;
        d_be     = 4'h5;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic isd;
            logic [31:0] dat;
            isd = (k % 2 == 0);
            dat = 32'h11110000 + 32'(k);
            push(isd ? 3'b010 : 3'b100, dat, 1'b0);
            step();
            bus_phase(0, dat, isd ? 32'h400 : 32'h300,
                      isd ? 4'h5 : 4'hF, 1'b0, 32'h0, 1'b0, n);
            chk("rr_len", 32'(n), 32'(1));
            resp_phase();
            t_ready[k] = cyc;
            step();
            idle_check("rr_gap");
        end
        chk("rr_d_period", 32'(t_ready[2] - t_ready[0]), 32'(6));
        chk("rr_i_period", 32'(t_ready[3] - t_ready[1]), 32'(6));
        if_req   = 1'b0;
        d_rd_req = 1'b0;
        step();
        step();

        // reset in the middle of a data write
        d_wr_req  = 1'b1;
        d_addr    = 32'h5000;
        d_be      = 4'hF;
        d_wr_data = 32'h55;
        step();
        chk("abort_bus", 32'(m_wr_req), 32'(1));
        rst      = 1'b1;
        d_wr_req = 1'b0;
        step();
        idle_check("abort_ctrl");
        chk("abort_addr", m_addr, 32'h0);
        chk("abort_out", if_data | d_rd_data | m_wr_data | 32'(m_be),
            32'h0);
        step();
        idle_check("abort_hold");
        rst = 1'b0;

        // first conflict after reset goes to D, then the fetch
        if_req   = 1'b1;
        if_addr  = 32'h600;
        d_rd_req = 1'b1;
        d_addr   = 32'h700;
        push(3'b010, 32'h77, 1'b0);
        step();
        bus_phase(0, 32'h77, 32'h700, 4'hF, 1'b0, 32'h0, 1'b0, n);
        chk("post_d_len", 32'(n), 32'(1));
        resp_phase();
        step();
        d_rd_req = 1'b0;
        idle_check("post_d_after");
        push(3'b100, 32'h66, 1'b0);
        step();
        bus_phase(0, 32'h66, 32'h600, 4'hF, 1'b0, 32'h0, 1'b0, n);
        chk("post_i_len", 32'(n), 32'(1));
        resp_phase();
        step();
        if_req = 1'b0;
        idle_check("post_i_after");

        chk("sb_left", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
